// File: rtl/mask_pkg.sv
// Shared types and sizing for the mask frame controller.
// Holds the frame FSM state enum, default raster size and datapath widths.
package mask_pkg;

    localparam int H_ACTIVE_DFLT = 640;
    localparam int V_ACTIVE_DFLT = 480;
    localparam int COORD_W       = 10;
    localparam int CNT_W         = 19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/mask_raster_cnt.sv
// Raster-order x/y counter: clears to (0,0), steps x then y, wraps at frame end.
// Ports: clk, rst (async high), clr, step; x, y position; last = at final pixel.
module mask_raster_cnt
    import mask_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DFLT,
    parameter int V_ACTIVE = V_ACTIVE_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               step,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

    assign last = (x == X_MAX) && (y == Y_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mask_frame_ctrl.sv
// Frame controller for the mask generator: arms on enable, issues reads per pixel,
// drains returns, counts foreground pixels and reports frame_done.
// Ports: clk_25, rst (async high), enable, thr_wr/thr_data/thr_ack/thr_active,
// pix_valid/pix_x/pix_y, gen_read, gen_valid/gen_mask/gen_x/gen_y,
// busy, frame_done, fg_count, err_order.
// Option: define MASK_FRAME_CTRL_ORDER_CHECK_EN for return-order checking;
// without it err_order is tied low.
module mask_frame_ctrl
    import mask_pkg::*;
#(
    parameter int          H_ACTIVE  = H_ACTIVE_DFLT,
    parameter int          V_ACTIVE  = V_ACTIVE_DFLT,
    parameter logic [31:0] THR_RESET = 32'd300
) (
    input  logic               clk_25,
    input  logic               rst,
    input  logic               enable,
    input  logic               thr_wr,
    input  logic [31:0]        thr_data,
    output logic               thr_ack,
    output logic [31:0]        thr_active,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               gen_read,
    input  logic               gen_valid,
    input  logic               gen_mask,
    input  logic [COORD_W-1:0] gen_x,
    input  logic [COORD_W-1:0] gen_y,
    output logic               busy,
    output logic               frame_done,
    output logic [CNT_W-1:0]   fg_count,
    output logic               err_order
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

    state_t           state;
    logic [31:0]      thr_shadow;
    logic [1:0]       outstanding;
    logic [CNT_W-1:0] run_count;
    logic             start;
    logic             last_read;
    logic             ret_ok;

    // Frame starts on the (0,0) pixel while armed and still enabled.
    assign start = (state == S_ARMED) && enable && pix_valid &&
                   (pix_x == '0) && (pix_y == '0);
    assign gen_read  = pix_valid && ((state == S_RUN) || start);
    assign last_read = gen_read && (pix_x == X_MAX) && (pix_y == Y_MAX);
    // A return is only honoured when a read is actually outstanding.
    assign ret_ok    = gen_valid && (outstanding != 2'd0);

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            fg_count   <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_ARMED;
                        busy  <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (!enable) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (start) begin
                        state <= last_read ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_read) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (outstanding == 2'd0) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        fg_count   <= run_count;
                    end
                end
                S_DONE: begin
                    state <= enable ? S_ARMED : S_IDLE;
                    busy  <= enable;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            thr_shadow  <= THR_RESET;
            thr_active  <= THR_RESET;
            thr_ack     <= 1'b0;
            outstanding <= 2'd0;
            run_count   <= '0;
        end else begin
            thr_ack <= thr_wr;
            if (thr_wr) thr_shadow <= thr_data;
            // Old shadow wins when a write lands on the start cycle.
            if (start) thr_active <= thr_shadow;

            case ({gen_read, ret_ok})
                2'b10: if (outstanding != 2'd3) outstanding <= outstanding + 1'b1;
                2'b01: outstanding <= outstanding - 1'b1;
                default: ;
            endcase

            if (start) begin
                run_count <= '0;
            end else if (ret_ok && !gen_mask && (run_count != '1)) begin
                run_count <= run_count + 1'b1;
            end
        end
    end

`ifdef MASK_FRAME_CTRL_ORDER_CHECK_EN
    logic [COORD_W-1:0] exp_x;
    logic [COORD_W-1:0] exp_y;
    logic               exp_last;
    logic               ret_all;

    mask_raster_cnt #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE)
    ) u_exp (
        .clk (clk_25),
        .rst (rst),
        .clr (start),
        .step(ret_ok),
        .x   (exp_x),
        .y   (exp_y),
        .last(exp_last)
    );

    // ret_all: every pixel of this frame has already been returned.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            err_order <= 1'b0;
            ret_all   <= 1'b0;
        end else begin
            if (start) ret_all <= 1'b0;
            else if (ret_ok && exp_last) ret_all <= 1'b1;
            if ((gen_valid && (outstanding == 2'd0)) ||
                (gen_read && (outstanding == 2'd3)) ||
                (ret_ok && ((gen_x != exp_x) || (gen_y != exp_y) || ret_all)))
                err_order <= 1'b1;
        end
    end
`else
    logic unused_coords;
    assign unused_coords = ^{gen_x, gen_y};
    assign err_order = 1'b0;
`endif

endmodule

// File: doc/mask_frame_ctrl.md
MASK_FRAME_CTRL -- requirements
Module: mask_frame_ctrl

Interface
REQ-001 Parameters SHALL be: H_ACTIVE, 640, active pixels per line; V_ACTIVE, 480, active lines per frame; THR_RESET, 32'd300, threshold value after reset.
REQ-002 Clocking SHALL be one clock, clk_25; reset SHALL be asynchronous and active-high, port rst.
REQ-003 clk_25  in  1  pixel clock, all logic rising-edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 enable  in  1  run request; sampled at frame boundaries only.
REQ-006 thr_wr  in  1  one-cycle threshold write strobe, ALT side.
REQ-007 thr_data  in  32  threshold value written.
REQ-008 thr_ack  out  1  one-cycle write acknowledge.
REQ-009 thr_active  out  32  threshold driven to mask generator.
REQ-010 pix_valid, pix_x, pix_y  in  1/10/10  pixel strobe and raster coordinates from sync controller.
REQ-011 gen_read  out  1  read strobe to mask generator.
REQ-012 gen_valid, gen_mask, gen_x, gen_y  in  1/1/10/10  mask result and its coordinates.
REQ-013 busy  out  1  high in ARMED, RUN, DRAIN.
REQ-014 frame_done  out  1  one-cycle end-of-frame pulse.
REQ-015 fg_count  out  19  foreground pixels (gen_mask==0) in last completed frame.
REQ-016 err_order  out  1  sticky return-order/protocol error.

Function
REQ-017 FSM states SHALL be IDLE, ARMED, RUN, DRAIN, DONE; reset state IDLE.
REQ-018 IDLE->ARMED when enable=1; ARMED->IDLE when enable=0.
REQ-019 ARMED->RUN on pix_valid with pix_x=0, pix_y=0; that cycle SHALL copy threshold shadow into thr_active and clear the running count.
REQ-020 gen_read SHALL be combinational: pix_valid AND (state RUN, or ARMED taking the RUN transition); zero latency.
REQ-021 RUN->DRAIN in the cycle gen_read issues at (H_ACTIVE-1, V_ACTIVE-1).
REQ-022 Outstanding counter (2 bits) SHALL +1 on gen_read, -1 on gen_valid, unchanged if both; DRAIN->DONE when counter is 0.
REQ-023 DONE SHALL last one cycle: frame_done=1, fg_count loaded from running count; then ARMED if enable=1, else IDLE.
REQ-024 enable deasserted in RUN/DRAIN SHALL NOT abort the frame.
REQ-025 Running count SHALL increment on gen_valid with gen_mask=0, 19-bit, saturating at all-ones.
REQ-026 Expected-return coordinates SHALL step in raster order from (0,0); a gen_valid whose gen_x/gen_y mismatch SHALL set err_order.
REQ-027 gen_valid with outstanding=0 SHALL set err_order and SHALL NOT change count or counter.
REQ-028 gen_read with outstanding=3 SHALL set err_order; counter saturates at 3.
REQ-029 thr_wr SHALL load shadow and pulse thr_ack next cycle in any state; thr_active changes only per REQ-019.
REQ-030 thr_wr coinciding with the RUN transition: thr_active gets old shadow, shadow gets thr_data.
REQ-031 pix_valid outside RUN/ARMED-transition SHALL be ignored; no gen_read.

Reset
REQ-032 On rst: state IDLE, thr_active and shadow=THR_RESET, fg_count=0, counters 0, thr_ack/frame_done/gen_read/busy/err_order=0.
REQ-033 rst mid-frame SHALL discard in-flight results; no frame_done produced.

Configuration
REQ-034 Macro MASK_FRAME_CTRL_ORDER_CHECK_EN defined: REQ-026 to REQ-028 checking implemented; undefined: err_order tied 0, expected-coordinate registers absent, all else identical.

Structure
REQ-035 Shared package mask_pkg SHALL hold the state enum, H_ACTIVE/V_ACTIVE defaults, coordinate width 10, count width 19.
REQ-036 One sub-module mask_raster_cnt (x/y raster counter with wrap and last-pixel flag) SHALL serve the expected-return tracker.

Verification
REQ-037 enable=1, full 640x480 frame, generator latency 2, all gen_mask=1 -> frame_done once, fg_count=0, err_order=0.
REQ-038 Same frame, gen_mask=0 for y<10 -> fg_count=6400.
REQ-039 thr_wr 500 mid-frame -> thr_ack next cycle, thr_active stays 300 until next (0,0), then 500.
REQ-040 gen_y corrupted on one return -> err_order=1 and stays 1 through next frame.
REQ-041 enable=0 at pixel (100,200) -> frame completes, frame_done pulses, state IDLE, busy=0.
REQ-042 rst at pixel (320,240) -> all outputs at reset values next cycle, no frame_done.
